// File: rtl/avalon_arb_pkg.sv
// Shared types and default widths for the two-master Avalon RAM arbiter.
package avalon_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    // IDLE: nobody owns the RAM; GNT_I: fetch master owns it; GNT_D: data master owns it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/avalon_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: with both masters requesting, the one not served last wins.
module rr_arb2 (
    input  logic req_i,
    input  logic req_d,
    input  logic last_d,
    output logic pick_i,
    output logic pick_d
);

    // Combinational pick; at most one of pick_i/pick_d is ever high.
    always_comb begin
        pick_d = req_d & (~req_i | ~last_d);
        pick_i = req_i & (~req_d | last_d);
    end

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Arbiter sharing one Avalon-MM RAM port between the CPU fetch and data masters.
// A grant is held for exactly one complete transfer and may hand over without an idle bubble.
module avalon_mem_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    // fetch master
    input  logic [ADDR_W-1:0]   i_address,
    input  logic                i_read,
    output logic [DATA_W-1:0]   i_readdata,
    output logic                i_waitrequest,
    // data master
    input  logic [ADDR_W-1:0]   d_address,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W-1:0]   d_writedata,
    input  logic [DATA_W/8-1:0] d_byteenable,
    output logic [DATA_W-1:0]   d_readdata,
    output logic                d_waitrequest,
    // RAM side
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W-1:0]   readdata,
    input  logic                waitrequest,
    // debug
    output logic                grant_i,
    output logic                grant_d
);

    arb_state_t state_q, state_d;
    logic       last_d_q, last_d_d;
    logic       req_i, req_d;
    logic       pick_i, pick_d;
    logic       done_i, done_d;

    assign req_i = i_read;
    assign req_d = d_read | d_write;

    rr_arb2 u_rr_arb2 (
        .req_i  (req_i),
        .req_d  (req_d),
        .last_d (last_d_q),
        .pick_i (pick_i),
        .pick_d (pick_d)
    );

    // A transfer completes when the owner is still requesting and the RAM does not stall.
    always_comb begin
        done_i = (state_q == GNT_I) && i_read && !waitrequest;
        done_d = (state_q == GNT_D) && req_d  && !waitrequest;
    end

    // Next grant and last-served master; the finishing master never re-wins on its own completion.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        unique case (state_q)
            IDLE: begin
                if (pick_d)      state_d = GNT_D;
                else if (pick_i) state_d = GNT_I;
            end
            GNT_I: begin
                if (!i_read) begin
                    state_d = IDLE;
                end else if (done_i) begin
                    last_d_d = 1'b0;
                    state_d  = req_d ? GNT_D : IDLE;
                end
            end
            GNT_D: begin
                if (!req_d) begin
                    state_d = IDLE;
                end else if (done_d) begin
                    last_d_d = 1'b1;
                    state_d  = req_i ? GNT_I : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and fairness registers with synchronous reset; a mid-transfer reset simply drops the grant.
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    assign grant_i    = (state_q == GNT_I);
    assign grant_d    = (state_q == GNT_D);
    assign i_readdata = readdata;
    assign d_readdata = readdata;

    // Route the owner's request to the RAM and its stall back; everyone else sees a stall.
    // NOTE: every output gets a default before the case so no latch can be inferred.
    always_comb begin
        address       = '0;
        read          = 1'b0;
        write         = 1'b0;
        writedata     = '0;
        byteenable    = '0;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
        unique case (state_q)
            GNT_I: begin
                address       = i_address;
                read          = i_read;
                byteenable    = '1;
                i_waitrequest = waitrequest;
            end
            GNT_D: begin
                address       = d_address;
                read          = d_read;
                write         = d_write;
                writedata     = d_writedata;
                byteenable    = d_byteenable;
                d_waitrequest = waitrequest;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Directed bench: both masters and the RAM are modelled here; a scoreboard holds each
// master's expected transfers and a log records who completed in which cycle.
module tb_avalon_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] i_address;
    logic          i_read;
    logic [DW-1:0] i_readdata;
    logic          i_waitrequest;
    logic [AW-1:0] d_address;
    logic          d_read, d_write;
    logic [DW-1:0] d_writedata;
    logic [BW-1:0] d_byteenable;
    logic [DW-1:0] d_readdata;
    logic          d_waitrequest;
    logic [AW-1:0] address;
    logic          read, write;
    logic [DW-1:0] writedata;
    logic [BW-1:0] byteenable;
    logic [DW-1:0] readdata;
    logic          waitrequest;
    logic          grant_i, grant_d;

    always #5 clk = ~clk;

    avalon_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_address     (i_address),
        .i_read        (i_read),
        .i_readdata    (i_readdata),
        .i_waitrequest (i_waitrequest),
        .d_address     (d_address),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_writedata   (d_writedata),
        .d_byteenable  (d_byteenable),
        .d_readdata    (d_readdata),
        .d_waitrequest (d_waitrequest),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .waitrequest   (waitrequest),
        .grant_i       (grant_i),
        .grant_d       (grant_d)
    );

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] data;   // write data, or expected read data
        logic [3:0]  be;
        int          start;  // earliest cycle the master may raise the request
    } cmd_t;

    typedef struct {
        logic is_d;
        int   cyc;
    } done_t;

    cmd_t        i_cmd_q[$], d_cmd_q[$], i_exp_q[$], d_exp_q[$];
    done_t       log_q[$];
    logic [31:0] mem     [16];  // RAM model contents
    logic [31:0] ref_mem [16];  // bench's own expectation of RAM contents
    int          vectors = 0, miscompares = 0;
    int          cyc = 0, stall_left = 0, gd_cycles = 0;
    logic        i_act = 1'b0, d_act = 1'b0;

    // RAM model: 16 words, zero-latency read data addressed by the arbiter's address.
    assign readdata = mem[address[5:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_i(input logic [31:0] a, input int start_off);
        cmd_t c;
        c.is_write = 1'b0;
        c.addr     = a;
        c.data     = ref_mem[a[5:2]];
        c.be       = 4'hF;
        c.start    = cyc + start_off;
        i_cmd_q.push_back(c);
        i_exp_q.push_back(c);
    endtask

    task automatic push_d(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input int start_off);
        cmd_t c;
        c.is_write = w;
        c.addr     = a;
        c.be       = be;
        c.start    = cyc + start_off;
        if (w) begin
            c.data = wd;
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[a[5:2]][8*b +: 8] = wd[8*b +: 8];
        end else begin
            c.data = ref_mem[a[5:2]];
        end
        d_cmd_q.push_back(c);
        d_exp_q.push_back(c);
    endtask

    // Negedge sampling: bus invariants, RAM model update, completion scoreboard.
    task automatic sample(output logic i_fin, output logic d_fin);
        cmd_t e;
        i_fin = 1'b0;
        d_fin = 1'b0;
        assert (!(d_read && d_write)) else begin
            miscompares++;
            $error("FAIL d_read_write_both observed=1 expected=0");
        end
        check("grant_onehot", 32'(grant_i & grant_d), 32'd0);
        if (!grant_i) check("i_wait_not_granted", 32'(i_waitrequest), 32'd1);
        else          check("i_wait_mirror", 32'(i_waitrequest), 32'(waitrequest));
        if (!grant_d) check("d_wait_not_granted", 32'(d_waitrequest), 32'd1);
        else          check("d_wait_mirror", 32'(d_waitrequest), 32'(waitrequest));
        if (!grant_i && !grant_d) begin
            check("idle_rw", 32'({read, write}), 32'd0);
            check("idle_addr", address, 32'd0);
            check("idle_be_wd", 32'(byteenable) | writedata, 32'd0);
        end
        if (grant_i) check("fetch_be_write", 32'({write, byteenable}), 32'h0F);
        if (grant_d) gd_cycles++;
        if ((read || write) && waitrequest && stall_left > 0) stall_left--;
        if (write && !waitrequest)
            for (int b = 0; b < 4; b++)
                if (byteenable[b]) mem[address[5:2]][8*b +: 8] = writedata[8*b +: 8];

        if (i_act && i_read && !i_waitrequest) begin
            i_fin = 1'b1;
            log_q.push_back('{1'b0, cyc});
            if (i_exp_q.size() == 0) begin
                check("i_unexpected_completion", 32'd1, 32'd0);
            end else begin
                e = i_exp_q.pop_front();
                check("i_ram_addr", address, e.addr);
                check("i_ram_read", 32'(read), 32'd1);
                check("i_readdata", i_readdata, e.data);
            end
        end
        if (d_act && (d_read || d_write) && !d_waitrequest) begin
            d_fin = 1'b1;
            log_q.push_back('{1'b1, cyc});
            if (d_exp_q.size() == 0) begin
                check("d_unexpected_completion", 32'd1, 32'd0);
            end else begin
                e = d_exp_q.pop_front();
                check("d_ram_addr", address, e.addr);
                check("d_ram_rw", 32'({read, write}), 32'({~e.is_write, e.is_write}));
                if (e.is_write) begin
                    check("d_writedata", writedata, e.data);
                    check("d_byteenable", 32'(byteenable), 32'(e.be));
                end else begin
                    check("d_readdata", d_readdata, e.data);
                end
            end
        end
    endtask

    // Runs both master models until all queued commands complete or the budget expires.
    task automatic run(input int max_cycles, input bit must_drain);
        logic i_fin = 1'b0, d_fin = 1'b0;
        cmd_t c;
        for (int k = 0; k < max_cycles; k++) begin
            if (i_fin) begin i_read = 1'b0; i_act = 1'b0; end
            if (d_fin) begin d_read = 1'b0; d_write = 1'b0; d_act = 1'b0; end
            if (!i_act && i_cmd_q.size() > 0 && i_cmd_q[0].start <= cyc) begin
                c = i_cmd_q.pop_front();
                i_address = c.addr;
                i_read    = 1'b1;
                i_act     = 1'b1;
            end
            if (!d_act && d_cmd_q.size() > 0 && d_cmd_q[0].start <= cyc) begin
                c = d_cmd_q.pop_front();
                d_address    = c.addr;
                d_read       = ~c.is_write;
                d_write      = c.is_write;
                d_writedata  = c.is_write ? c.data : 32'h0;
                d_byteenable = c.be;
                d_act        = 1'b1;
            end
            if (!i_act && !d_act && i_cmd_q.size() == 0 && d_cmd_q.size() == 0) return;
            waitrequest = (stall_left > 0);
            @(negedge clk);
            sample(i_fin, d_fin);
            @(posedge clk);
            #1;
            cyc++;
        end
        if (must_drain) begin
            vectors++;
            miscompares++;
            $error("FAIL drain_timeout observed=busy expected=idle after %0d cycles", max_cycles);
        end
    endtask

    // One-cycle synchronous reset that also abandons any in-flight master transfer.
    task automatic do_reset();
        reset = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_act = 1'b0;  d_act = 1'b0;
        i_cmd_q.delete(); d_cmd_q.delete(); i_exp_q.delete(); d_exp_q.delete();
        log_q.delete();
        stall_left = 0;
        waitrequest = 1'b0;
        @(posedge clk);
        #1;
        check("rst_grant_i", 32'(grant_i), 32'd0);
        check("rst_grant_d", 32'(grant_d), 32'd0);
        check("rst_read", 32'(read), 32'd0);
        check("rst_write", 32'(write), 32'd0);
        check("rst_i_wait", 32'(i_waitrequest), 32'd1);
        check("rst_d_wait", 32'(d_waitrequest), 32'd1);
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic check_log(input string tag, input int idx, input logic is_d, input int at);
        if (log_q.size() <= idx) begin
            check({tag, "_missing"}, 32'(log_q.size()), 32'(idx + 1));
        end else begin
            check({tag, "_master"}, 32'(log_q[idx].is_d), 32'(is_d));
            check({tag, "_cycle"}, 32'(log_q[idx].cyc), 32'(at));
        end
    endtask

    initial begin
        reset = 1'b1;
        i_address = '0; i_read = 1'b0;
        d_address = '0; d_read = 1'b0; d_write = 1'b0;
        d_writedata = '0; d_byteenable = '0;
        waitrequest = 1'b0;
        for (int k = 0; k < 16; k++) begin
            mem[k]     = 32'hA500_0000 | 32'(k * 17);
            ref_mem[k] = 32'hA500_0000 | 32'(k * 17);
        end
        @(posedge clk);
        #1;

        // Lone fetch: granted and completed one cycle after it is first seen.
        do_reset();
        push_i(32'hBFC0_0000, 0);
        run(20, 1'b1);
        check("t1_count", 32'(log_q.size()), 32'd1);
        check_log("t1_fetch", 0, 1'b0, 1);

        // Simultaneous fetch and write after reset: data first, fetch on the next cycle.
        do_reset();
        push_i(32'hBFC0_0000, 0);
        push_d(1'b1, 32'hBFC0_0030, 32'h0000_1234, 4'hF, 0);
        run(20, 1'b1);
        check_log("t2_first", 0, 1'b1, 1);
        check_log("t2_second", 1, 1'b0, 2);
        push_d(1'b0, 32'hBFC0_0030, 32'h0, 4'hF, 0);
        run(20, 1'b1);

        // Both masters busy: eight alternating completions in eight consecutive cycles.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push_d(1'b0, 32'hBFC0_0020 + 32'(4 * k), 32'h0, 4'hF, 0);
            push_i(32'hBFC0_0000 + 32'(4 * k), 0);
        end
        run(40, 1'b1);
        check("t3_count", 32'(log_q.size()), 32'd8);
        for (int k = 0; k < 8; k++) check_log("t3_alt", k, (k % 2) == 0, k + 1);

        // RAM stalls a data read for three cycles; a fetch arriving meanwhile follows directly.
        do_reset();
        stall_left = 3;
        gd_cycles  = 0;
        push_d(1'b0, 32'hBFC0_0010, 32'h0, 4'hF, 0);
        push_i(32'hBFC0_0004, 2);
        run(30, 1'b1);
        check("t4_grant_d_cycles", 32'(gd_cycles), 32'd4);
        check_log("t4_data", 0, 1'b1, 4);
        check_log("t4_fetch", 1, 1'b0, 5);

        // Reset aborts a stalled fetch; last_d must be back at fetch so data wins next.
        do_reset();
        push_d(1'b1, 32'hBFC0_003C, 32'hCAFE_F00D, 4'b0011, 0);
        run(20, 1'b1);
        stall_left = 10;
        push_i(32'hBFC0_0008, 0);
        run(3, 1'b0);
        check("t5_stalled_grant_i", 32'(grant_i), 32'd1);
        do_reset();
        push_i(32'hBFC0_0008, 0);
        push_d(1'b0, 32'hBFC0_003C, 32'h0, 4'hF, 0);
        run(20, 1'b1);
        check_log("t5_first", 0, 1'b1, 1);
        check_log("t5_second", 1, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
